// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond
//   Conditions the raw car-presence sensors and parade push-buttons for the
//   traffic-light FSM. Every input is synchronized (2 flops) and debounced.
//   The street sensors are also stretched by a hold time. The buttons drive
//   a NORMAL/PARADE set/release latch.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles before db changes (1..255)
//   HOLD_CYCLES     : cycles o_TA/o_TB stay high after db falls (0..255)
//
// Ports
//   i_clk          : clock, rising edge
//   i_rstn         : synchronous active-low reset
//   i_sensor_a/b   : raw street A/B car sensors (asynchronous, bouncy)
//   i_btn_parade   : raw parade-start button, active-high
//   i_btn_release  : raw parade-release button, active-high
//   o_TA / o_TB    : conditioned traffic present on street A / B
//   o_M            : parade mode active
module traffic_sensor_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 64
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_sensor_a,
    input  logic i_sensor_b,
    input  logic i_btn_parade,
    input  logic i_btn_release,
    output logic o_TA,
    output logic o_TB,
    output logic o_M
);

    localparam logic [7:0] CNT_MAX   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

    // Channel index: 0 = sensor A, 1 = sensor B, 2 = parade, 3 = release
    localparam int unsigned NCH = 4;

    typedef enum logic {
        NORMAL = 1'b0,
        PARADE = 1'b1
    } state_t;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] db;
    logic [NCH-1:0] db_next;
    logic [7:0]     cnt      [NCH];
    logic [7:0]     cnt_next [NCH];
    logic [1:0]     btn_prev;
    logic [7:0]     hold_a;
    logic [7:0]     hold_b;
    logic [7:0]     hold_a_next;
    logic [7:0]     hold_b_next;
    logic           ev_parade;
    logic           ev_release;
    state_t         state_q;
    state_t         state_d;

    assign raw = {i_btn_release, i_btn_parade, i_sensor_b, i_sensor_a};

    // Debounce: a single agreeing cycle restarts the count.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            db_next[i]  = db[i];
            cnt_next[i] = '0;
            if (sync2[i] != db[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    db_next[i] = ~db[i];
                end else begin
                    cnt_next[i] = cnt[i] + 8'd1;
                end
            end
        end
    end

    // Load on the 1->0 edge of db; a rising or high db forces the stretch
    // off, so re-arrival during hold keeps the output high with no dip.
    function automatic logic [7:0] hold_step(input logic db_cur,
                                             input logic db_nxt,
                                             input logic [7:0] h);
        logic [7:0] r;
        r = h;
        if (db_cur && !db_nxt) begin
            r = HOLD_LOAD;
        end else if (db_cur || db_nxt) begin
            r = '0;
        end else if (h != '0) begin
            r = h - 8'd1;
        end
        return r;
    endfunction

    always_comb begin
        hold_a_next = hold_step(db[0], db_next[0], hold_a);
        hold_b_next = hold_step(db[1], db_next[1], hold_b);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sync1    <= '0;
            sync2    <= '0;
            db       <= '0;
            btn_prev <= '0;
            hold_a   <= '0;
            hold_b   <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            db       <= db_next;
            btn_prev <= db[3:2];
            hold_a   <= hold_a_next;
            hold_b   <= hold_b_next;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Button events: one per debounced press, regardless of hold length.
    assign ev_parade  = db[2] & ~btn_prev[0];
    assign ev_release = db[3] & ~btn_prev[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: if (ev_parade && !ev_release) state_d = PARADE;
            PARADE: if (ev_release && !ev_parade) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_TA = db[0] | (hold_a != '0);
    assign o_TB = db[1] | (hold_b != '0);
    assign o_M  = (state_q == PARADE);

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Testbench for traffic_sensor_cond (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8),
// plus a second instance with DEBOUNCE_CYCLES=1, HOLD_CYCLES=0.
module tb_traffic_sensor_cond;

    logic clk = 1'b0;
    logic rstn;
    logic sa, sb, bp, br;
    logic ta, tb, m;
    logic h0_ta, h0_tb, h0_m;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    traffic_sensor_cond #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_sensor_a   (sa),
        .i_sensor_b   (sb),
        .i_btn_parade (bp),
        .i_btn_release(br),
        .o_TA         (ta),
        .o_TB         (tb),
        .o_M          (m)
    );

    traffic_sensor_cond #(
        .DEBOUNCE_CYCLES(1),
        .HOLD_CYCLES    (0)
    ) dut_h0 (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_sensor_a   (sa),
        .i_sensor_b   (sb),
        .i_btn_parade (bp),
        .i_btn_release(br),
        .o_TA         (h0_ta),
        .o_TB         (h0_tb),
        .o_M          (h0_m)
    );

    typedef struct {
        int unsigned n;
        bit rstn, sa, sb, bp, br;
        bit ta, tb, m;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int unsigned n, input bit r, input bit a,
                                input bit b, input bit p, input bit rl,
                                input bit eta, input bit etb, input bit em);
        vec_t v;
        v.n = n; v.rstn = r; v.sa = a; v.sb = b; v.bp = p; v.br = rl;
        v.ta = eta; v.tb = etb; v.m = em;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise sensor A from idle and let o_TA settle high.
    task automatic a_rise();
        sa = 1'b1;
        for (int unsigned e = 1; e <= 10; e++) begin
            tick();
            chk($sformatf("a_rise_e%0d", e), {7'd0, ta}, {7'd0, (e >= 6)});
        end
    endtask

    // Drop sensor A: db falls at edge 6, o_TA falls at edge 14.
    task automatic a_fall();
        sa = 1'b0;
        for (int unsigned e = 1; e <= 16; e++) begin
            tick();
            chk($sformatf("a_fall_e%0d", e), {7'd0, ta}, {7'd0, (e < 14)});
        end
    endtask

    // Raw A drops, then rises again `gap` cycles after db_a has fallen.
    task automatic rearrive(input int unsigned gap);
        sa = 1'b0;
        for (int unsigned e = 1; e <= 5 + gap; e++) begin
            tick();
            chk($sformatf("rearr%0d_low_e%0d", gap, e), {7'd0, ta}, 8'd1);
        end
        sa = 1'b1;
        for (int unsigned e = 6 + gap; e <= 12 + gap; e++) begin
            tick();
            chk($sformatf("rearr%0d_high_e%0d", gap, e), {7'd0, ta}, 8'd1);
            if (e >= 11 + gap)
                chk($sformatf("rearr%0d_hold_a_e%0d", gap, e), dut.hold_a, 8'd0);
        end
    endtask

    initial begin
        rstn = 1'b0; sa = 1'b0; sb = 1'b0; bp = 1'b0; br = 1'b0;

        //   n  rstn sa sb bp br | TA TB M
        // reset with all inputs high, release with inputs low
        add( 3, 0, 1, 1, 1, 1,   0, 0, 0);
        add(12, 1, 0, 0, 0, 0,   0, 0, 0);
        // clean press on A: rise at edge 6, raw fall before edge 20, fall at 33
        add( 5, 1, 1, 0, 0, 0,   0, 0, 0);
        add( 1, 1, 1, 0, 0, 0,   1, 0, 0);
        add(13, 1, 1, 0, 0, 0,   1, 0, 0);
        add(13, 1, 0, 0, 0, 0,   1, 0, 0);
        add( 1, 1, 0, 0, 0, 0,   0, 0, 0);
        add( 4, 1, 0, 0, 0, 0,   0, 0, 0);
        // bounce on B never reaches the debounce threshold
        add( 2, 1, 0, 1, 0, 0,   0, 0, 0);
        add( 2, 1, 0, 0, 0, 0,   0, 0, 0);
        add( 2, 1, 0, 1, 0, 0,   0, 0, 0);
        add( 2, 1, 0, 0, 0, 0,   0, 0, 0);
        add( 8, 1, 0, 0, 0, 0,   0, 0, 0);
        // both streets at once, independent
        add( 5, 1, 1, 1, 0, 0,   0, 0, 0);
        add( 4, 1, 1, 1, 0, 0,   1, 1, 0);
        add(13, 1, 0, 0, 0, 0,   1, 1, 0);
        add( 3, 1, 0, 0, 0, 0,   0, 0, 0);
        // parade press held 10 cycles: o_M at edge 7
        add( 6, 1, 0, 0, 1, 0,   0, 0, 0);
        add( 4, 1, 0, 0, 1, 0,   0, 0, 1);
        add(10, 1, 0, 0, 0, 0,   0, 0, 1);
        // parade again while in PARADE: no effect
        add(10, 1, 0, 0, 1, 0,   0, 0, 1);
        add(10, 1, 0, 0, 0, 0,   0, 0, 1);
        // release: o_M falls at edge 7
        add( 6, 1, 0, 0, 0, 1,   0, 0, 1);
        add( 4, 1, 0, 0, 0, 1,   0, 0, 0);
        add(10, 1, 0, 0, 0, 0,   0, 0, 0);
        // release while NORMAL: no effect
        add(10, 1, 0, 0, 0, 1,   0, 0, 0);
        add(10, 1, 0, 0, 0, 0,   0, 0, 0);
        // simultaneous buttons in NORMAL
        add(10, 1, 0, 0, 1, 1,   0, 0, 0);
        add(10, 1, 0, 0, 0, 0,   0, 0, 0);
        // enter PARADE, then simultaneous buttons
        add( 6, 1, 0, 0, 1, 0,   0, 0, 0);
        add( 1, 1, 0, 0, 1, 0,   0, 0, 1);
        add(10, 1, 0, 0, 0, 0,   0, 0, 1);
        add(10, 1, 0, 0, 1, 1,   0, 0, 1);
        add(10, 1, 0, 0, 0, 0,   0, 0, 1);
        // reset mid-PARADE
        add( 1, 0, 0, 0, 0, 0,   0, 0, 0);
        add( 5, 1, 0, 0, 0, 0,   0, 0, 0);
        // reset mid-hold: no stretch afterwards
        add( 5, 1, 1, 0, 0, 0,   0, 0, 0);
        add( 3, 1, 1, 0, 0, 0,   1, 0, 0);
        add( 8, 1, 0, 0, 0, 0,   1, 0, 0);
        add( 1, 0, 0, 0, 0, 0,   0, 0, 0);
        add(10, 1, 0, 0, 0, 0,   0, 0, 0);

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            rstn = tbl[i].rstn; sa = tbl[i].sa; sb = tbl[i].sb;
            bp = tbl[i].bp; br = tbl[i].br;
            for (int unsigned k = 0; k < tbl[i].n; k++) begin
                tick();
                chk($sformatf("vec%0d_c%0d_TA", i, k), {7'd0, ta}, {7'd0, tbl[i].ta});
                chk($sformatf("vec%0d_c%0d_TB", i, k), {7'd0, tb}, {7'd0, tbl[i].tb});
                chk($sformatf("vec%0d_c%0d_M",  i, k), {7'd0, m},  {7'd0, tbl[i].m});
            end
        end

        // Re-arrival within the hold window
        rstn = 1'b1; sa = 1'b0; sb = 1'b0; bp = 1'b0; br = 1'b0;
        a_rise();
        rearrive(3);
        a_fall();
        a_rise();
        rearrive(1);
        a_fall();

        // HOLD_CYCLES = 0, DEBOUNCE_CYCLES = 1: db toggles at edge 3, no stretch
        sa = 1'b1;
        for (int unsigned e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("h0_rise_e%0d", e), {7'd0, h0_ta}, {7'd0, (e >= 3)});
        end
        sa = 1'b0;
        for (int unsigned e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("h0_fall_e%0d", e), {7'd0, h0_ta}, {7'd0, (e < 3)});
            chk($sformatf("h0_fall_hold_e%0d", e), dut_h0.hold_a, 8'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_cond.md
# traffic_sensor_cond

Input conditioning stage for the traffic-light controller. It takes raw, asynchronous car-presence sensors for street A and street B and the parade-mode push-buttons, and produces the clean `o_TA`, `o_TB` and `o_M` levels that the light FSM samples every cycle. Each input is synchronized and debounced. Traffic-present is stretched by a hold time so brief gaps between cars do not cycle the lights. Parade mode is a set/release latch driven by button edges.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive disagreeing cycles required before a debounced level changes. Legal range 1..255.
- `HOLD_CYCLES`, default 64: cycles that `o_TA`/`o_TB` stay high after the debounced sensor falls. Legal range 0..255. Value 0 means no stretch.

Ports:
- `i_clk`, input, 1: single clock. All state updates on its rising edge.
- `i_rstn`, input, 1: reset, synchronous, active-low.
- `i_sensor_a`, input, 1: raw street-A car sensor. Asynchronous, may bounce.
- `i_sensor_b`, input, 1: raw street-B car sensor. Asynchronous, may bounce.
- `i_btn_parade`, input, 1: raw parade-start button, active-high.
- `i_btn_release`, input, 1: raw parade-release button, active-high.
- `o_TA`, output, 1: traffic present on street A, conditioned.
- `o_TB`, output, 1: traffic present on street B, conditioned.
- `o_M`, output, 1: parade mode active.

## Operation
- **Synchronizer.** Each of the four raw inputs passes through its own 2-flop synchronizer. The second flop is the channel's `sync` value.
- **Debounce, per channel.** Each channel has an 8-bit counter `cnt` and a debounced level `db`.
  - On each edge with `sync != db`: if `cnt == DEBOUNCE_CYCLES-1`, toggle `db` and clear `cnt`. Otherwise increment `cnt`.
  - On each edge with `sync == db`: clear `cnt`. One agreeing cycle therefore restarts the count.
- **Hold stretch, A and B only.** Each of the two sensor channels has an 8-bit down-counter `hold`.
  - Edge where `db` toggles 1→0: load `hold = HOLD_CYCLES`.
  - `db` rising, or `db == 1`: force `hold = 0`.
  - Otherwise, if `hold != 0`: decrement `hold`.
  - `o_TA = db_a | (hold_a != 0)`. `o_TB` is formed the same way from channel B.
  - The output is an OR of registers only, so it is glitch-free.
- **Parade FSM.** Two states: `NORMAL` (`o_M = 0`) and `PARADE` (`o_M = 1`). `o_M` is a register.
  - Each button keeps a `db_prev` register. A rising event is `db & ~db_prev`.
  - `NORMAL` → `PARADE` on a parade rising event, unless a release rising event occurs in the same cycle.
  - `PARADE` → `NORMAL` on a release rising event, unless a parade rising event occurs in the same cycle.
  - Simultaneous rising events on both buttons leave the state unchanged.
  - Holding a button down produces exactly one event.
  - A parade event while already in `PARADE`, or a release event while in `NORMAL`, has no effect.
- **Channel independence.** The A and B channels are fully independent. Both may be asserted at once, and the downstream FSM arbitrates.

## Timing
- **Reset.** While `i_rstn == 0` at a rising edge, the following are all cleared to 0: synchronizer flops, `db`, `db_prev`, `cnt`, `hold`, and the FSM state (`NORMAL`).
  - Outputs `o_TA`, `o_TB` and `o_M` read 0 after that edge.
  - Reset mid-debounce or mid-hold discards all progress. There is no stretch after reset.
- **Debounce latency.** Raw input changes before edge 1 and then stays stable.
  - `sync` reflects the new value after edge 2.
  - `db` toggles at edge `2+DEBOUNCE_CYCLES`.
  - `o_TA`/`o_TB` rise at edge `2+DEBOUNCE_CYCLES`.
- **Fall latency.** After a stable raw fall, `db` falls at edge `2+DEBOUNCE_CYCLES`. `o_TA` falls at edge `2+DEBOUNCE_CYCLES+HOLD_CYCLES`.
  - With `HOLD_CYCLES = 0`, `o_TA` falls together with `db`.
- **Re-arrival during hold.** A new debounced rise while `hold != 0` clears `hold`. `o_TA` stays continuously high, with no 0-cycle dip.
- **Parade latency.** `o_M` changes at edge `3+DEBOUNCE_CYCLES` after a stable raw button press: one edge after the button's `db` rises.
- **Glitches.** A raw pulse shorter than `DEBOUNCE_CYCLES` cycles, as seen at `sync`, never changes `db` or any output.
- **Counter width.** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.

## Test plan
Directed scenarios use `DEBOUNCE_CYCLES = 4`, `HOLD_CYCLES = 8`.
1. **Reset.** Hold `i_rstn = 0` for 3 edges with all inputs high, then release with all inputs low → `o_TA = o_TB = o_M = 0` throughout, with no stretch pulse.
2. **Clean press.** `i_sensor_a` 0→1 before edge 1 and held → `o_TA` rises at edge 6. Then drop to 0 before edge 20 → `o_TA` falls at edge 33 (20+5+8).
3. **Bounce rejection.** `i_sensor_b` toggles 1,0,1,0 every 2 cycles, then stays 0 → `o_TB` stays 0 throughout.
4. **Re-arrival in hold window.** `i_sensor_a` falls, then rises again 3 cycles after `db_a` falls → `o_TA` stays high continuously and `hold_a` reads 0 after the re-rise.
5. **Parade FSM.**
   - Press `i_btn_parade` for 10 cycles → `o_M` = 1 at edge 7.
   - Press parade again → no change.
   - Press `i_btn_release` → `o_M` = 0, 7 edges after press start.
6. **Simultaneous buttons.** Both buttons rise on the same cycle while in `NORMAL` → `o_M` stays 0. Assert reset mid-`PARADE` → `o_M` = 0 on the next edge.
